clock_div_ctrl: RTL and testbench

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

---
 rtl/clock_div_ctrl_pkg.sv | 13 +
 rtl/clock_div_ctrl_cnt.sv | 41 ++++
 rtl/clock_div_ctrl.sv | 132 +++++++++++++
 tb/tb_clock_div_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_ctrl_pkg.sv
// Shared types and defaults for the clock_div_ctrl programmable clock divider.
package clock_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int unsigned DEF_CNT_W     = 32;
  localparam logic [31:0] DEF_DIV_RESET = 32'd5000000;

endpackage

// File: rtl/clock_div_ctrl_cnt.sv
// Half-period counter: counts 1..div while enabled, flags the terminal count and reloads to 1.
module clock_div_ctrl_cnt
  import clock_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // count is only zero while parked, so a zero count never matches a live div
  assign term  = (count_q != '0) && (count_q == div);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = '0;
    end else if (term || (count_q == '0)) begin
      count_d = CNT_W'(1);
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// Start/stop controlled clock divider with a ready/valid divide-value port.
// Optional macro CLK_DIV_CTRL_TOGCNT_EN adds a 16-bit toggle_count output.
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W     = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEF_DIV_RESET)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             sclk,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_TOGCNT_EN
  ,
  output logic [15:0]      toggle_count
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             sclk_q, sclk_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cnt_en;
  logic             term;
  logic             cfg_hs;
  logic [CNT_W-1:0] count_unused;

  clock_div_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .div   (div_q),
    .count (count_unused),
    .term  (term)
  );

  assign cfg_ready = !pend_vld_q;
  assign cfg_err   = cfg_err_q;
  assign sclk      = sclk_q;
  assign tick      = tick_q;
  assign busy      = (state_q != IDLE);
  assign cfg_hs    = cfg_valid && cfg_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start && !stop) state_d = RUN;
      // a stop landing on the falling toggle can park immediately
      RUN:      if (stop) state_d = (sclk_q && !term) ? STOPPING : IDLE;
      STOPPING: begin
        if (start && !stop) state_d = RUN;
        else if (term)      state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    cnt_en = (state_d != IDLE);

    sclk_d = sclk_q;
    if (state_d == IDLE) sclk_d = 1'b0;
    else if (term)       sclk_d = ~sclk_q;
    tick_d = sclk_d ^ sclk_q;

    cfg_err_d  = cfg_hs && (cfg_div == '0);
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (pend_vld_q && (term || (state_d == IDLE))) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    // a new offer is only possible with nothing pending, so these never collide
    if (cfg_hs && (cfg_div != '0)) begin
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        div_d = cfg_div;
      end else begin
        pend_d     = cfg_div;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= DIV_RESET;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      sclk_q     <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      sclk_q     <= sclk_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef CLK_DIV_CTRL_TOGCNT_EN
  logic [15:0] tog_q, tog_d;

  always_comb begin
    tog_d = tog_q;
    if ((state_q == IDLE) && (state_d == RUN)) tog_d = 16'd0;
    else if (tick_d)                           tog_d = tog_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) tog_q <= 16'd0;
    else       tog_q <= tog_d;
  end

  assign toggle_count = tog_q;
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed self-checking bench for clock_div_ctrl (DIV_RESET overridden to 7 for short runs).
module tb_clock_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic        sclk;
  logic        tick;
  logic        busy;
`ifdef CLK_DIV_CTRL_TOGCNT_EN
  logic [15:0] toggle_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clock_div_ctrl #(
    .CNT_W     (32),
    .DIV_RESET (32'd7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_div      (cfg_div),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .sclk         (sclk),
    .tick         (tick),
    .busy         (busy)
`ifdef CLK_DIV_CTRL_TOGCNT_EN
    ,
    .toggle_count (toggle_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bit i of s_bits/t_bits is the expected sclk/tick after i+1 further edges
  task automatic run_chk(input string tag, input int n, input logic [31:0] s_bits,
                         input logic [31:0] t_bits);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_sclk"}, {31'd0, sclk}, {31'd0, s_bits[i]});
      chk({tag, "_tick"}, {31'd0, tick}, {31'd0, t_bits[i]});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = 32'd0;
    step(); step();
    chk("rst_sclk",  {31'd0, sclk},      32'd0);
    chk("rst_tick",  {31'd0, tick},      32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_err",   {31'd0, cfg_err},   32'd0);
    reset = 1'b0;

    // div=4 accepted in IDLE, then run: toggles every 4 cycles
    cfg_valid = 1'b1; cfg_div = 32'd4;
    step();
    cfg_valid = 1'b0;
    chk("idle_cfg_err", {31'd0, cfg_err}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_sclk0", {31'd0, sclk}, 32'd0);
    run_chk("div4", 16, 32'h7878, 32'h8888);

    // div=2 offered mid half-period: pending until the next toggle
    step();
    chk("pend_ready_before", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1; cfg_div = 32'd2;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready_low", {31'd0, cfg_ready}, 32'd0);
    step();
    chk("pend_ready_low2", {31'd0, cfg_ready}, 32'd0);
    chk("pend_hold_sclk",  {31'd0, sclk},      32'd0);
    step();
    chk("pend_apply_ready", {31'd0, cfg_ready}, 32'd1);
    chk("pend_apply_sclk",  {31'd0, sclk},      32'd1);
    chk("pend_apply_tick",  {31'd0, tick},      32'd1);
    run_chk("div2", 4, 32'h9, 32'hA);

    // zero divide rejected in RUN
    cfg_valid = 1'b1; cfg_div = 32'd0;
    step();
    cfg_valid = 1'b0;
    chk("run_zero_err",   {31'd0, cfg_err},   32'd1);
    chk("run_zero_ready", {31'd0, cfg_ready}, 32'd1);
    step();
    chk("run_zero_err_off", {31'd0, cfg_err}, 32'd0);
    chk("run_zero_sclk",    {31'd0, sclk},    32'd0);
    chk("run_zero_tick",    {31'd0, tick},    32'd1);
    run_chk("div2_keep", 2, 32'h2, 32'h2);
    step(); step();
    chk("stop_low_pre_sclk", {31'd0, sclk}, 32'd0);

    // stop with sclk low: idle on the next edge
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_low_busy", {31'd0, busy}, 32'd0);
    chk("stop_low_sclk", {31'd0, sclk}, 32'd0);
    chk("stop_low_tick", {31'd0, tick}, 32'd0);

    // zero divide rejected in IDLE, div stays 2
    cfg_valid = 1'b1; cfg_div = 32'd0;
    step();
    cfg_valid = 1'b0;
    chk("idle_zero_err",   {31'd0, cfg_err},   32'd1);
    chk("idle_zero_ready", {31'd0, cfg_ready}, 32'd1);
    chk("idle_zero_busy",  {31'd0, busy},      32'd0);
    step();
    chk("idle_zero_err_off", {31'd0, cfg_err}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    run_chk("div2_after_zero", 2, 32'h2, 32'h2);

    // div=3 via pending, then stop with sclk high goes through STOPPING
    cfg_valid = 1'b1; cfg_div = 32'd3;
    step();
    cfg_valid = 1'b0;
    chk("div3_ready_low", {31'd0, cfg_ready}, 32'd0);
    step();
    chk("div3_apply_ready", {31'd0, cfg_ready}, 32'd1);
    chk("div3_apply_tick",  {31'd0, tick},      32'd1);
    run_chk("div3", 3, 32'h4, 32'h4);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stopping_busy", {31'd0, busy}, 32'd1);
    chk("stopping_sclk", {31'd0, sclk}, 32'd1);
    chk("stopping_tick", {31'd0, tick}, 32'd0);
    step();
    chk("stopped_busy", {31'd0, busy}, 32'd0);
    chk("stopped_sclk", {31'd0, sclk}, 32'd0);
    chk("stopped_tick", {31'd0, tick}, 32'd1);
    step();
    chk("stopped_tick_off", {31'd0, tick}, 32'd0);

    // start+stop together: stop wins in RUN and in IDLE
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; stop = 1'b1;
    step();
    chk("both_run_busy", {31'd0, busy}, 32'd0);
    step();
    start = 1'b0; stop = 1'b0;
    chk("both_idle_busy", {31'd0, busy}, 32'd0);

    // start during STOPPING resumes with the count undisturbed
    start = 1'b1;
    step();
    start = 1'b0;
    run_chk("resume_pre", 3, 32'h4, 32'h4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("resume_stopping_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("resume_busy", {31'd0, busy}, 32'd1);
    chk("resume_sclk", {31'd0, sclk}, 32'd1);
    step();
    chk("resume_fall_sclk", {31'd0, sclk}, 32'd0);
    chk("resume_fall_tick", {31'd0, tick}, 32'd1);
    run_chk("resume_post", 3, 32'h4, 32'h4);
    chk("resume_post_busy", {31'd0, busy}, 32'd1);

    // reset mid-RUN with sclk high
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_sclk",  {31'd0, sclk},      32'd0);
    chk("midrst_tick",  {31'd0, tick},      32'd0);
    chk("midrst_busy",  {31'd0, busy},      32'd0);
    chk("midrst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("midrst_err",   {31'd0, cfg_err},   32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    run_chk("div_reset7", 7, 32'h40, 32'h40);

    // pending value survives the stop and is applied on entry to IDLE
    step();
    cfg_valid = 1'b1; cfg_div = 32'd2;
    step();
    cfg_valid = 1'b0;
    chk("idle_pend_ready", {31'd0, cfg_ready}, 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_pend_stopping_ready", {31'd0, cfg_ready}, 32'd0);
    step(); step(); step();
    chk("idle_pend_busy_hi", {31'd0, busy}, 32'd1);
    step();
    chk("idle_pend_busy_lo", {31'd0, busy}, 32'd0);
    chk("idle_pend_sclk",    {31'd0, sclk}, 32'd0);
    chk("idle_pend_tick",    {31'd0, tick}, 32'd1);
    chk("idle_pend_ready_hi", {31'd0, cfg_ready}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    run_chk("idle_pend_div2", 2, 32'h2, 32'h2);

`ifdef CLK_DIV_CTRL_TOGCNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("tog_rst", {16'd0, toggle_count}, 32'd0);
    cfg_valid = 1'b1; cfg_div = 32'd1;
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tog_start", {16'd0, toggle_count}, 32'd0);
    step();
    chk("tog_first", {16'd0, toggle_count}, 32'd1);
    for (int i = 1; i < 65536; i++) step();
    chk("tog_wrap", {16'd0, toggle_count}, 32'd0);
    step();
    chk("tog_after_wrap", {16'd0, toggle_count}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
